// File: rtl/selftrigger_frame_capture_if.sv
// selftrigger_frame_capture_if: valid/ready frame readout stream
interface selftrigger_frame_capture_if;
    logic [15:0] dout;
    logic        dout_valid;
    logic        dout_last;
    logic        dout_ready;
    modport master(output dout, dout_valid, dout_last, input dout_ready);
    modport slave(input dout, dout_valid, dout_last, output dout_ready);
endinterface

// File: rtl/selftrigger_frame_capture.sv
// selftrigger_frame_capture: circular pre/post-trigger frame capture with timestamped readout
module selftrigger_frame_capture #(
    parameter int PRE_SAMPLES = 32,
    parameter int FRAME_LEN   = 128,
    parameter int ADDR_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic signed [15:0]          x,
    input  logic                        trigger,
    input  logic [63:0]                 timestamp,
    selftrigger_frame_capture_if.master stream,
    output logic                        busy,
    output logic [15:0]                 missed_count
);
    localparam int CW     = $clog2(FRAME_LEN + 5);
    localparam int POST_N = FRAME_LEN - PRE_SAMPLES;
    typedef enum logic [1:0] {IDLE, ARMED, POST, READOUT} state_t;
    state_t            state, state_n;
    logic [15:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] wptr, raddr;
    logic [CW-1:0]     fill, post_cnt, rcnt;
    logic [63:0]       ts_q;
    logic [15:0]       ts_word;
    logic              wr, accept, load, done;

    assign wr      = enable && state != READOUT;
    assign accept  = enable && trigger && state == ARMED;
    assign load    = state == READOUT && rcnt != CW'(FRAME_LEN + 4) && (!stream.dout_valid || stream.dout_ready);
    assign done    = stream.dout_valid && stream.dout_ready && stream.dout_last;
    assign busy    = state == POST || state == READOUT;
    assign ts_word = rcnt[1] ? (rcnt[0] ? ts_q[15:0] : ts_q[31:16]) : (rcnt[0] ? ts_q[47:32] : ts_q[63:48]);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_n;
    end

    // Next state: enable loss abandons capture, readout always runs to its last word
    always_comb begin
        state_n = state;
        if (state != READOUT && !enable) state_n = IDLE;
        else if (state == IDLE && fill == CW'(PRE_SAMPLES - 1)) state_n = ARMED;
        else if (accept) state_n = POST_N == 1 ? READOUT : POST;
        else if (state == POST && post_cnt == CW'(1)) state_n = READOUT;
        else if (done) state_n = IDLE;
    end

    // Sample buffer; left unreset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= x;
    end

    // Write pointer, fill/post counters, trigger capture and read address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            raddr    <= '0;
            fill     <= '0;
            post_cnt <= '0;
            rcnt     <= '0;
            ts_q     <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if ((state != READOUT && !enable) || done) fill <= '0;
            else if (state == IDLE) fill <= fill + 1'b1;
            if (accept) begin
                ts_q     <= timestamp;
                raddr    <= wptr - ADDR_W'(PRE_SAMPLES);
                post_cnt <= CW'(POST_N - 1);
                rcnt     <= '0;
            end else begin
                if (state == POST && enable) post_cnt <= post_cnt - 1'b1;
                if (load) rcnt <= rcnt + 1'b1;
                if (load && rcnt >= CW'(4)) raddr <= raddr + 1'b1;
            end
        end
    end

    // Output register: loads the next word whenever empty or being accepted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stream.dout       <= '0;
            stream.dout_valid <= 1'b0;
            stream.dout_last  <= 1'b0;
        end else if (load) begin
            stream.dout       <= rcnt < CW'(4) ? ts_word : mem[raddr];
            stream.dout_valid <= 1'b1;
            stream.dout_last  <= rcnt == CW'(FRAME_LEN + 3);
        end else if (stream.dout_ready) begin
            stream.dout_valid <= 1'b0;
            stream.dout_last  <= 1'b0;
        end
    end

    // Saturating count of triggers seen while not armed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) missed_count <= '0;
        else if (enable && trigger && state != ARMED && missed_count != 16'hFFFF) missed_count <= missed_count + 1'b1;
    end
endmodule

// File: tb/tb_selftrigger_frame_capture.sv
// tb_selftrigger_frame_capture: directed/randomized bench with a frame-level reference model
module tb_selftrigger_frame_capture;
    localparam int PRE = 32, FL = 128, AW = 8;
    logic clk = 0, reset = 1, enable = 0, trigger = 0, rdy = 1;
    logic signed [15:0] x = 0;
    logic [63:0] timestamp = 0;
    logic busy;
    logic [15:0] missed_count;
    int n_cmp = 0, n_bad = 0;
    int mode = 0, cnt = 0, need = 0, age = 0, missed_m = 0, frames = 0, cyc = 0, vrun = 0, f0 = 0, m0 = 0;
    bit gap = 0, seen = 0, bp = 0, rnd_x = 0, fixed_ts = 0;
    logic [15:0] hist[$], fr[$], exp_q[$], log_q[$];
    logic [15:0] tv;
    logic [63:0] ts_base = 64'h0000_00A5_0000_0000;

    selftrigger_frame_capture_if bus();
    assign bus.dout_ready = rdy;

    selftrigger_frame_capture #(.PRE_SAMPLES(PRE), .FRAME_LEN(FL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .x(x), .trigger(trigger),
        .timestamp(timestamp), .stream(bus), .busy(busy), .missed_count(missed_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bump();
        if (missed_m < 65535) missed_m++;
    endtask

    // One clock: sample the handshake, advance the model with the driven inputs, check outputs
    task automatic tick();
        bit hs, stall;
        logic [15:0] hw, e;
        logic hl;
        hs = bus.dout_valid && rdy;
        stall = bus.dout_valid && !rdy;
        hw = bus.dout;
        hl = bus.dout_last;
        if (mode == 2) begin
            if (bus.dout_valid) begin vrun++; seen = 1; end
            else if (seen) gap = 1;
        end
        @(posedge clk);
        cyc++;
        case (mode)
            0: if (!enable) begin
                cnt = 0; hist.delete();
            end else if (trigger && cnt >= PRE) begin
                fr.delete();
                for (int i = 3; i >= 0; i--) fr.push_back(16'(timestamp >> (16 * i)));
                foreach (hist[i]) fr.push_back(hist[i]);
                fr.push_back(x);
                need = FL - PRE - 1;
                mode = 1;
            end else begin
                if (trigger) bump();
                hist.push_back(x);
                if (hist.size() > PRE) void'(hist.pop_front());
                cnt++;
            end
            1: if (!enable) begin
                mode = 0; cnt = 0; hist.delete(); fr.delete();
            end else begin
                if (trigger) bump();
                fr.push_back(x);
                need--;
                if (need == 0) begin exp_q = fr; mode = 2; age = 0; end
            end
            default: begin
                if (enable && trigger) bump();
                age++;
            end
        endcase
        if (hs) begin
            chk("word_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                log_q.push_back(hw);
                chk("dout", hw, e);
                chk("dout_last", hl, exp_q.size() == 0);
                if (exp_q.size() == 0) begin mode = 0; cnt = 0; hist.delete(); frames++; end
            end
        end
        #1;
        chk("busy", busy, mode != 0);
        chk("missed_count", missed_count, missed_m);
        if (stall) begin
            chk("hold_valid", bus.dout_valid, 1);
            chk("hold_dout", bus.dout, hw);
            chk("hold_last", bus.dout_last, hl);
        end
        if (mode == 2 && age == 2) chk("first_valid_latency", bus.dout_valid, 1);
    endtask

    task automatic step(input bit en, input bit trg);
        enable = en;
        trigger = trg;
        x = rnd_x ? 16'($urandom) : 16'(cyc);
        if (!fixed_ts) timestamp = ts_base + 64'(cyc);
        rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
    endtask

    task automatic do_reset();
        reset = 0; enable = 0; trigger = 0;
        #1;
        chk("rst_dout", bus.dout, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_last", bus.dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_missed", missed_count, 0);
        mode = 0; cnt = 0; missed_m = 0;
        hist.delete(); fr.delete(); exp_q.delete();
        repeat (2) tick();
        reset = 1;
        cyc = 0;
    endtask

    task automatic wait_idle(input bit en, input int budget);
        for (int i = 0; i < budget && mode != 0; i++) step(en, 0);
        chk("drain_timeout", mode, 0);
    endtask

    task automatic wait_read(input int budget);
        for (int i = 0; i < budget && mode != 2; i++) step(1, 0);
        chk("wait_readout", mode, 2);
    endtask

    task automatic basic_frame(input string tag);
        do_reset();
        log_q.delete(); vrun = 0; gap = 0; seen = 0;
        fixed_ts = 1; timestamp = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i <= 500; i++) step(1, i == 500);
        wait_idle(1, 1000);
        chk({tag, "_size"}, log_q.size(), FL + 4);
        chk({tag, "_ts0"}, log_q[0], 16'h0123);
        chk({tag, "_ts1"}, log_q[1], 16'h4567);
        chk({tag, "_ts2"}, log_q[2], 16'h89AB);
        chk({tag, "_ts3"}, log_q[3], 16'hCDEF);
        chk({tag, "_first"}, log_q[4], 468);
        chk({tag, "_last"}, log_q[FL + 3], 595);
        chk({tag, "_missed"}, missed_count, 0);
    endtask

    initial begin
        #2;
        bp = 0;
        basic_frame("basic");
        chk("cont_valid_cycles", vrun, FL + 4);
        chk("cont_no_gap", gap, 0);

        bp = 1;
        basic_frame("bp");

        bp = 0; fixed_ts = 0;
        repeat (1000) step(1, 0);
        log_q.delete();
        tv = 16'(cyc);
        step(1, 1);
        wait_idle(1, 600);
        chk("wrap_size", log_q.size(), FL + 4);
        chk("wrap_first", log_q[4], 16'(tv - 16'd32));
        for (int i = 5; i < FL + 4; i++) chk("wrap_contig", log_q[i], 16'(log_q[i - 1] + 16'd1));

        do_reset();
        bp = 1; f0 = frames;
        for (int i = 0; i < 60; i++) step(1, i == 10);
        step(1, 1);
        for (int k = 0; k < 200 && mode == 1; k++) step(1, k == 5 || k == 20 || k == 40);
        for (int k = 0; k < 1000 && mode != 0; k++) step(1, mode == 2 && (age == 3 || age == 10));
        chk("overlap_missed", missed_count, 6);
        chk("overlap_frames", frames - f0, 1);

        bp = 0;
        repeat (40) step(1, 0);
        f0 = frames;
        step(1, 1);
        repeat (20) step(1, 0);
        repeat (3) step(0, 0);
        chk("drop_post_busy", busy, 0);
        repeat (31) step(1, 0);
        m0 = missed_m;
        step(1, 1);
        chk("rearm_early_missed", missed_count, m0 + 1);
        chk("rearm_early_busy", busy, 0);
        step(1, 1);
        chk("rearm_busy", busy, 1);
        wait_idle(1, 600);
        chk("drop_post_frames", frames - f0, 1);

        bp = 1;
        repeat (40) step(1, 0);
        f0 = frames;
        step(1, 1);
        wait_read(200);
        repeat (10) step(1, 0);
        wait_idle(0, 1000);
        chk("drop_read_frames", frames - f0, 1);

        rnd_x = 1;
        repeat (40) step(1, 0);
        log_q.delete();
        step(1, 1);
        for (int k = 0; k < 2000 && log_q.size() < 51; k++) step(1, 0);
        chk("reached_word50", log_q.size(), 51);
        do_reset();
        f0 = frames;
        repeat (32) step(1, 0);
        step(1, 1);
        chk("post_reset_busy", busy, 1);
        wait_idle(1, 1000);
        chk("post_reset_frames", frames - f0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
